// File: rtl/rc4_cipher_store_if.sv
// Signal bundle between the RC4 engine (master) and the ciphertext store (slave).
// A write strobe or read pulse is one cycle wide; a served read answers with valid one cycle later.
interface rc4_cipher_store_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          cipher_write;
    logic [DW-1:0] cipher_out;
    logic          cipher_read;
    logic [DW-1:0] cipher_in;
    logic          cipher_in_valid;
    logic [AW:0]   byte_count;
    logic          overflow;
    logic          proto_err;
    logic          drained;

    modport master (
        output cipher_write, cipher_out, cipher_read,
        input  cipher_in, cipher_in_valid, byte_count, overflow, proto_err, drained
    );

    modport slave (
        input  cipher_write, cipher_out, cipher_read,
        output cipher_in, cipher_in_valid, byte_count, overflow, proto_err, drained
    );
endinterface

// File: rtl/rc4_cipher_store.sv
// Ciphertext store: records the engine's cipher bytes during encrypt, then replays
// them in order during decrypt and answers with valid low once the stream is exhausted.
module rc4_cipher_store #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    rc4_cipher_store_if.slave       bus,
    output logic [1:0]              state_dbg
);
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_eff;
    logic [DW-1:0] cipher_in_q, rd_data;
    logic          valid_q, overflow_q, proto_err_q, drained_q;
    logic          wr_accept, wr_full, wr_proto, rd_serve, rd_hit, rd_fwd;

    // Handshake: a cipher_read sampled at edge k is answered by cipher_in/cipher_in_valid
    // held for exactly the cycle after edge k; valid=0 in that cycle means end-of-stream.
    always_comb begin
        state_d   = state_q;
        wr_accept = 1'b0;
        wr_full   = 1'b0;
        wr_proto  = 1'b0;
        rd_serve  = 1'b0;
        case (state_q)
            FILL: begin
                // wr_ptr never exceeds DEPTH, so its top bit alone means full
                wr_accept = bus.cipher_write && !wr_ptr[AW];
                wr_full   = bus.cipher_write && wr_ptr[AW];
                if (bus.cipher_read) begin
                    rd_serve = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                wr_proto = bus.cipher_write;
                rd_serve = bus.cipher_read;
            end
            DONE: begin
                wr_proto = bus.cipher_write;
            end
            default: state_d = FILL;
        endcase
        wr_ptr_eff = wr_ptr + (AW+1)'(wr_accept);
        rd_hit     = rd_serve && (rd_ptr < wr_ptr_eff);
        rd_fwd     = wr_accept && (rd_ptr == wr_ptr);
        rd_data    = rd_fwd ? bus.cipher_out : mem[rd_ptr[AW-1:0]];
        if (rd_serve && !rd_hit) state_d = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cipher_in_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            drained_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= rd_hit;
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (wr_full) overflow_q <= 1'b1;
            if (wr_proto) proto_err_q <= 1'b1;
            if (rd_hit) begin
                cipher_in_q <= rd_data;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (state_d == DONE) drained_q <= 1'b1;
        end
    end

    // Contents are not cleared on reset; a new stream overwrites from address 0.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[AW-1:0]] <= bus.cipher_out;
    end

    assign bus.cipher_in       = cipher_in_q;
    assign bus.cipher_in_valid = valid_q;
    assign bus.byte_count      = wr_ptr;
    assign bus.overflow        = overflow_q;
    assign bus.proto_err       = proto_err_q;
    assign bus.drained         = drained_q;
    assign state_dbg           = state_q;
endmodule

// File: tb/tb_rc4_cipher_store.sv
// Directed bench for rc4_cipher_store: fill/drain, empty read, overflow, protocol
// error, same-edge write+read forwarding and reset mid-drain.
module tb_rc4_cipher_store;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 8;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         total;
  int         bad;

  rc4_cipher_store_if #(.AW(AW), .DW(DW)) bus ();

  rc4_cipher_store #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.cipher_write = 1'b0;
    bus.cipher_read  = 1'b0;
    bus.cipher_out   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [DW-1:0] val);
    bus.cipher_write = 1'b1;
    bus.cipher_out   = val;
    @(posedge clk);
    #1;
    bus.cipher_write = 1'b0;
  endtask

  task automatic do_read();
    bus.cipher_read = 1'b1;
    @(posedge clk);
    #1;
    bus.cipher_read = 1'b0;
  endtask

  task automatic test_reset();
    do_write(8'h99);
    do_read();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({bus.cipher_in, bus.cipher_in_valid, bus.byte_count, bus.overflow,
         bus.proto_err, bus.drained, state_dbg} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got in=%h v=%b cnt=%0d ov=%b pe=%b dr=%b st=%0d want all 0",
               bus.cipher_in, bus.cipher_in_valid, bus.byte_count, bus.overflow,
               bus.proto_err, bus.drained, state_dbg);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals [3];
    vals[0] = 8'h3A;
    vals[1] = 8'h7F;
    vals[2] = 8'h00;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_write(vals[i]);
      repeat (3) idle_cycle();
    end
    total++;
    if (bus.byte_count !== 7'd3) begin
      bad++;
      $display("FAIL fill_count: got %0d want 3", bus.byte_count);
    end
    for (int i = 0; i < 3; i++) begin
      do_read();
      total++;
      if (bus.cipher_in_valid !== 1'b1 || bus.cipher_in !== vals[i]) begin
        bad++;
        $display("FAIL drain_data[%0d]: got v=%b %h want v=1 %h", i, bus.cipher_in_valid,
                 bus.cipher_in, vals[i]);
      end
      idle_cycle();
      total++;
      if (bus.cipher_in_valid !== 1'b0) begin
        bad++;
        $display("FAIL drain_valid_pulse[%0d]: got v=%b want 0", i, bus.cipher_in_valid);
      end
    end
    do_read();
    total++;
    if (bus.cipher_in_valid !== 1'b0 || bus.drained !== 1'b1 || bus.cipher_in !== 8'h00
        || state_dbg !== 2'd2) begin
      bad++;
      $display("FAIL drain_end: got v=%b dr=%b in=%h st=%0d want v=0 dr=1 in=00 st=2",
               bus.cipher_in_valid, bus.drained, bus.cipher_in, state_dbg);
    end
  endtask

  task automatic test_empty_read();
    apply_reset();
    do_read();
    total++;
    if (bus.cipher_in_valid !== 1'b0 || bus.drained !== 1'b1 || bus.byte_count !== 7'd0
        || bus.overflow !== 1'b0 || bus.proto_err !== 1'b0) begin
      bad++;
      $display("FAIL empty_read: got v=%b dr=%b cnt=%0d ov=%b pe=%b want v=0 dr=1 cnt=0 ov=0 pe=0",
               bus.cipher_in_valid, bus.drained, bus.byte_count, bus.overflow, bus.proto_err);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_write(DW'(i));
    total++;
    if (bus.byte_count !== 7'd64 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_no_overflow: got cnt=%0d ov=%b want cnt=64 ov=0",
               bus.byte_count, bus.overflow);
    end
    do_write(8'd64);
    total++;
    if (bus.byte_count !== 7'd64 || bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got cnt=%0d ov=%b want cnt=64 ov=1",
               bus.byte_count, bus.overflow);
    end
    // Back-to-back read pulses, one per cycle.
    bus.cipher_read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.cipher_in_valid !== 1'b1 || bus.cipher_in !== DW'(i)) begin
        bad++;
        $display("FAIL overflow_drain[%0d]: got v=%b %h want v=1 %h", i,
                 bus.cipher_in_valid, bus.cipher_in, DW'(i));
      end
    end
    @(posedge clk);
    #1;
    bus.cipher_read = 1'b0;
    total++;
    if (bus.cipher_in_valid !== 1'b0 || bus.drained !== 1'b1) begin
      bad++;
      $display("FAIL overflow_end: got v=%b dr=%b want v=0 dr=1",
               bus.cipher_in_valid, bus.drained);
    end
  endtask

  task automatic test_proto_err();
    apply_reset();
    do_write(8'h11);
    do_read();
    total++;
    if (bus.cipher_in_valid !== 1'b1 || bus.cipher_in !== 8'h11 || state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL proto_first_read: got v=%b %h st=%0d want v=1 11 st=1",
               bus.cipher_in_valid, bus.cipher_in, state_dbg);
    end
    do_write(8'h22);
    total++;
    if (bus.proto_err !== 1'b1 || bus.byte_count !== 7'd1 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL proto_err_set: got pe=%b cnt=%0d ov=%b want pe=1 cnt=1 ov=0",
               bus.proto_err, bus.byte_count, bus.overflow);
    end
    do_read();
    total++;
    if (bus.cipher_in_valid !== 1'b0 || bus.drained !== 1'b1) begin
      bad++;
      $display("FAIL proto_end: got v=%b dr=%b want v=0 dr=1", bus.cipher_in_valid, bus.drained);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.cipher_write = 1'b1;
    bus.cipher_out   = 8'hA5;
    bus.cipher_read  = 1'b1;
    @(posedge clk);
    #1;
    bus.cipher_write = 1'b0;
    bus.cipher_read  = 1'b0;
    total++;
    if (bus.cipher_in_valid !== 1'b1 || bus.cipher_in !== 8'hA5 || bus.byte_count !== 7'd1
        || bus.drained !== 1'b0) begin
      bad++;
      $display("FAIL forward: got v=%b %h cnt=%0d dr=%b want v=1 a5 cnt=1 dr=0",
               bus.cipher_in_valid, bus.cipher_in, bus.byte_count, bus.drained);
    end
    idle_cycle();
    total++;
    if (bus.cipher_in_valid !== 1'b0) begin
      bad++;
      $display("FAIL forward_pulse: got v=%b want 0", bus.cipher_in_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int i = 0; i < 10; i++) do_write(8'h40 + DW'(i));
    for (int i = 0; i < 4; i++) begin
      do_read();
      total++;
      if (bus.cipher_in_valid !== 1'b1 || bus.cipher_in !== 8'h40 + DW'(i)) begin
        bad++;
        $display("FAIL mid_drain[%0d]: got v=%b %h want v=1 %h", i, bus.cipher_in_valid,
                 bus.cipher_in, 8'h40 + DW'(i));
      end
    end
    bus.cipher_read = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cipher_read = 1'b0;
    total++;
    if ({bus.cipher_in, bus.cipher_in_valid, bus.byte_count, bus.overflow,
         bus.proto_err, bus.drained, state_dbg} !== '0) begin
      bad++;
      $display("FAIL mid_drain_reset: got in=%h v=%b cnt=%0d ov=%b pe=%b dr=%b st=%0d want all 0",
               bus.cipher_in, bus.cipher_in_valid, bus.byte_count, bus.overflow,
               bus.proto_err, bus.drained, state_dbg);
    end
    do_write(8'h5C);
    do_read();
    total++;
    if (bus.cipher_in_valid !== 1'b1 || bus.cipher_in !== 8'h5C || bus.byte_count !== 7'd1) begin
      bad++;
      $display("FAIL new_stream: got v=%b %h cnt=%0d want v=1 5c cnt=1",
               bus.cipher_in_valid, bus.cipher_in, bus.byte_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.cipher_write = 1'b0;
    bus.cipher_read  = 1'b0;
    bus.cipher_out   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_fill_drain();
    test_empty_read();
    test_overflow();
    test_proto_err();
    test_back_to_back();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
